ex_muldiv_seq: RTL and testbench
================================

Name: ex_muldiv_seq

Overview:
Iterative RV32M multiply/divide sequencer in the EX stage. It sits beside the single-cycle ALU and takes SrcA and the post-mux SrcB from the same operand path. It captures an M-extension op, runs a 32-iteration shift-add multiply or restoring divide, and holds the pipeline stall while busy. The result is returned on the EX result path in a one-cycle DONE slot.

Parameters:
DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_WIDTH

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
MDStartE  in  1  M-extension op present in EX; held high while stalled
MDOpE  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
SrcAE  in  DATA_WIDTH  rs1 operand
SrcBE  in  DATA_WIDTH  rs2 operand
FlushE  in  1  EX flush (branch/jump redirect)
MDStallE  out  1  hold F/D/E registers
MDValidE  out  1  MDResultE valid this cycle
MDResultE  out  DATA_WIDTH  product/quotient/remainder
MDBusy  out  1  FSM not in IDLE

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. Reset (including mid-operation) forces IDLE.
- Reset values: MDStallE=0, MDValidE=0, MDResultE=0, MDBusy=0, counter=0.
- States: IDLE, CALC, DONE.
- IDLE:
  - MDStallE = MDStartE & ~FlushE, combinational.
  - On MDStartE & ~FlushE: latch op, operand magnitudes and sign flags; go to CALC with counter=0.
  - Divide-by-zero (SrcBE==0, op 1xx) goes directly to DONE.
- CALC:
  - MDStallE=1.
  - One iteration per cycle.
  - Multiply: 2*DATA_WIDTH accumulator, shift-add on multiplier LSB.
  - Divide: restoring; shift remainder left, subtract divisor, set quotient bit if no borrow.
  - Go to DONE after iteration DATA_WIDTH-1.
- DONE:
  - MDStallE=0, MDValidE=1, MDResultE driven from the registered final value.
  - Unconditionally return to IDLE next cycle.
  - MDStartE is not re-sampled in DONE; it belongs to the retiring instruction.
- Latency: start cycle = T0. MDStallE is high T0..T32 (33 cycles). MDValidE is high at T33 only.
- Signed handling:
  - MUL/MULH: both operands signed.
  - MULHSU: A signed, B unsigned.
  - DIV/REM: both operands signed.
  - Operate on magnitudes, then negate the result per sign flags:
    - product sign = signA^signB;
    - quotient sign = signA^signB;
    - remainder sign = signA.
- Result select:
  - MUL = low word of the 64-bit product; MULH* = high word.
  - DIV/DIVU = quotient; REM/REMU = remainder.
- Divide-by-zero (RISC-V spec): quotient = all ones; remainder = SrcA unmodified.
- Signed overflow: DIV 0x80000000 / -1 = 0x80000000; REM = 0. This falls out naturally from magnitude arithmetic; it must be covered by the bench.
- FlushE in CALC or DONE: abort to IDLE next cycle; MDValidE forced 0 in that cycle; MDStallE=0.
- MDStartE deasserting during CALC without FlushE is a protocol violation; behaviour is unspecified.
- MDResultE holds its last value outside DONE. It is not consumed unless MDValidE=1.

Decomposition:
- Shared package (riscv_pkg):
  - md_op_e enum for the eight funct3 codes;
  - md_state_e {IDLE, CALC, DONE};
  - constant MD_ITER = DATA_WIDTH.
- One sub-module, muldiv_iter_dp: the registered accumulator/remainder/quotient shift datapath, with per-cycle step enable and load.
- The FSM, counter, sign fix-up and stall/valid generation stay in ex_muldiv_seq.

Test Plan:
1. MUL 7 x -3 (0x00000007, 0xFFFFFFFD) -> MDStallE high 33 cycles; MDValidE at T33 with 0xFFFFFFEB; MULH same operands -> 0xFFFFFFFF.
2. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF(-1) x 0xFFFFFFFF -> 0xFFFFFFFF.
3. DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
4. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0; DIVU 5/0 -> 0xFFFFFFFF with valid at T1; REM 5/0 -> 5.
5. FlushE pulse at T10 of a DIV -> MDBusy=0 at T11, no MDValidE; next MDStartE at T12 completes normally.
6. rst_n low at T5 of a MUL -> all outputs 0 immediately (async); back-to-back MUL then DIV with MDStartE held -> exactly two MDValidE pulses, 34 cycles apart.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared M-extension op codes, sequencer states and iteration constants
package riscv_pkg;

  localparam int XLEN    = 32;
  localparam int MD_ITER = XLEN;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/ex_muldiv_seq_if.sv
// rtl/ex_muldiv_seq_if.sv - EX-stage operand/result bundle between the pipeline and the mul/div sequencer
interface ex_muldiv_seq_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  MDStartE;
  logic [2:0]            MDOpE;
  logic [DATA_WIDTH-1:0] SrcAE;
  logic [DATA_WIDTH-1:0] SrcBE;
  logic                  FlushE;
  logic                  MDStallE;
  logic                  MDValidE;
  logic [DATA_WIDTH-1:0] MDResultE;
  logic                  MDBusy;

  modport master (
    output MDStartE, MDOpE, SrcAE, SrcBE, FlushE,
    input  MDStallE, MDValidE, MDResultE, MDBusy
  );

  modport slave (
    input  MDStartE, MDOpE, SrcAE, SrcBE, FlushE,
    output MDStallE, MDValidE, MDResultE, MDBusy
  );
endinterface

// File: rtl/muldiv_iter_dp.sv
// rtl/muldiv_iter_dp.sv - shared shift datapath: hi/lo hold product accumulator or remainder/quotient
module muldiv_iter_dp #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         step,
  input  logic         is_div,
  input  logic [W-1:0] load_a,
  input  logic [W-1:0] load_b,
  output logic [W-1:0] hi_nxt,
  output logic [W-1:0] lo_nxt
);

  logic [W-1:0] hi_q, lo_q, b_q;
  logic [W:0]   mul_sum;
  logic [W:0]   div_shift;
  logic [W:0]   div_diff;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_shift = {hi_q, lo_q[W-1]};
    div_diff  = div_shift - {1'b0, b_q};
    hi_nxt    = mul_sum[W:1];
    lo_nxt    = {mul_sum[0], lo_q[W-1:1]};
    if (is_div) begin
      // The shifted remainder is below 2*divisor, so the top bit of the difference is the borrow.
      if (!div_diff[W]) begin
        hi_nxt = div_diff[W-1:0];
        lo_nxt = {lo_q[W-2:0], 1'b1};
      end else begin
        hi_nxt = div_shift[W-1:0];
        lo_nxt = {lo_q[W-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
      b_q  <= '0;
    end else if (load) begin
      hi_q <= '0;
      lo_q <= load_a;
      b_q  <= load_b;
    end else if (step) begin
      hi_q <= hi_nxt;
      lo_q <= lo_nxt;
    end
  end

endmodule

// File: rtl/ex_muldiv_seq.sv
// rtl/ex_muldiv_seq.sv - iterative RV32M multiply/divide sequencer with EX stall and one-cycle DONE slot
module ex_muldiv_seq
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = MD_ITER,
  parameter int CNT_W      = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  ex_muldiv_seq_if.slave     md
);

  localparam int W = DATA_WIDTH;

  md_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  md_op_e         op_q;
  logic           sign_a_q, sign_b_q;
  logic [W-1:0]   result_q, res_d;
  logic           res_we, dp_load, dp_step;
  logic           start, div0, sa_d, sb_d;
  logic [W-1:0]   a_mag, b_mag, hi_nxt, lo_nxt, final_res;
  logic [2*W-1:0] prod, prod_s;

  assign start = md.MDStartE && !md.FlushE;
  assign div0  = md.MDOpE[2] && (md.SrcBE == '0);

  always_comb begin
    sa_d = 1'b0;
    sb_d = 1'b0;
    case (md_op_e'(md.MDOpE))
      MD_MUL, MD_MULH, MD_DIV, MD_REM: begin
        sa_d = md.SrcAE[W-1];
        sb_d = md.SrcBE[W-1];
      end
      MD_MULHSU: sa_d = md.SrcAE[W-1];
      default: ;
    endcase
    a_mag = sa_d ? -md.SrcAE : md.SrcAE;
    b_mag = sb_d ? -md.SrcBE : md.SrcBE;
  end

  muldiv_iter_dp #(.W(W)) u_dp (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (dp_load),
    .step   (dp_step),
    .is_div (op_q[2]),
    .load_a (a_mag),
    .load_b (b_mag),
    .hi_nxt (hi_nxt),
    .lo_nxt (lo_nxt)
  );

  // Magnitude results are sign-corrected on the final iteration so DONE serves a registered value.
  always_comb begin
    prod      = {hi_nxt, lo_nxt};
    prod_s    = (sign_a_q ^ sign_b_q) ? -prod : prod;
    final_res = prod_s[2*W-1:W];
    case (op_q)
      MD_MUL:          final_res = prod_s[W-1:0];
      MD_DIV, MD_DIVU: final_res = (sign_a_q ^ sign_b_q) ? -lo_nxt : lo_nxt;
      MD_REM, MD_REMU: final_res = sign_a_q ? -hi_nxt : hi_nxt;
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dp_load     = 1'b0;
    dp_step     = 1'b0;
    res_we      = 1'b0;
    res_d       = final_res;
    md.MDStallE = 1'b0;
    md.MDValidE = 1'b0;
    case (state_q)
      IDLE: begin
        md.MDStallE = start;
        if (start) begin
          dp_load = 1'b1;
          cnt_d   = '0;
          state_d = div0 ? DONE : CALC;
          res_we  = div0;
          res_d   = md.MDOpE[1] ? md.SrcAE : '1;
        end
      end
      CALC: begin
        if (md.FlushE) begin
          state_d = IDLE;
        end else begin
          md.MDStallE = 1'b1;
          dp_step     = 1'b1;
          cnt_d       = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            state_d = DONE;
            res_we  = 1'b1;
          end
        end
      end
      DONE: begin
        md.MDValidE = !md.FlushE;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= MD_MUL;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (dp_load) begin
        op_q     <= md_op_e'(md.MDOpE);
        sign_a_q <= sa_d;
        sign_b_q <= sb_d;
      end
      if (res_we) result_q <= res_d;
    end
  end

  assign md.MDResultE = result_q;
  assign md.MDBusy    = (state_q != IDLE);

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// tb/tb_ex_muldiv_seq.sv - vector table, corner sequences and randomized model check for ex_muldiv_seq
module tb_ex_muldiv_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  ex_muldiv_seq_if #(.DATA_WIDTH(32)) md ();

  ex_muldiv_seq #(.DATA_WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .md    (md.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, zb;
    logic [63:0] za, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    za = {32'b0, a};
    zb = {32'b0, b};
    case (op)
      3'd0: begin p = za * zb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * zb; return p[63:32]; end
      3'd3: begin p = za * zb; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int stalls);
    lat    = -1;
    stalls = 0;
    res    = '0;
    @(negedge clk);
    md.MDOpE    = op;
    md.SrcAE    = a;
    md.SrcBE    = b;
    md.MDStartE = 1'b1;
    for (int k = 0; k < 60; k++) begin
      #1;
      if (md.MDStallE) stalls++;
      if (md.MDValidE) begin
        lat = k;
        res = md.MDResultE;
        break;
      end
      @(negedge clk);
    end
    md.MDStartE = 1'b0;
  endtask

  initial begin
    logic [31:0] res, a, b;
    logic [2:0]  op;
    int          lat, stalls, pulses, first_k, second_k;
    logic [31:0] r1, r2;

    md.MDStartE = 1'b0;
    md.MDOpE    = 3'd0;
    md.SrcAE    = '0;
    md.SrcBE    = '0;
    md.FlushE   = 1'b0;

    vecs[0]  = '{3'd0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 33};
    vecs[1]  = '{3'd1, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 33};
    vecs[2]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    vecs[3]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
    vecs[4]  = '{3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33};
    vecs[5]  = '{3'd6, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33};
    vecs[6]  = '{3'd5, 32'd100,      32'd7,        32'd14,       33};
    vecs[7]  = '{3'd7, 32'd100,      32'd7,        32'd2,        33};
    vecs[8]  = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33};
    vecs[9]  = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33};
    vecs[10] = '{3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
    vecs[11] = '{3'd6, 32'd5,        32'd0,        32'd5,        1};

    #1;
    chk("reset_stall", {31'b0, md.MDStallE}, 32'd0);
    chk("reset_valid", {31'b0, md.MDValidE}, 32'd0);
    chk("reset_busy",  {31'b0, md.MDBusy},   32'd0);
    chk("reset_result", md.MDResultE, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, stalls);
      chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_stalls", i), stalls, vecs[i].lat);
    end

    // Flush mid-divide, then a clean restart.
    @(negedge clk);
    md.MDOpE = 3'd4; md.SrcAE = 32'd1000; md.SrcBE = 32'd3; md.MDStartE = 1'b1;
    repeat (10) @(negedge clk);
    #1 md.FlushE = 1'b1;
    #1;
    chk("flush_stall", {31'b0, md.MDStallE}, 32'd0);
    chk("flush_valid", {31'b0, md.MDValidE}, 32'd0);
    @(negedge clk);
    md.FlushE = 1'b0;
    md.MDStartE = 1'b0;
    #1;
    chk("flush_busy_after", {31'b0, md.MDBusy}, 32'd0);
    chk("flush_valid_after", {31'b0, md.MDValidE}, 32'd0);
    run_op(3'd4, 32'd1000, 32'd3, res, lat, stalls);
    chk("flush_restart_result", res, 32'd333);
    chk("flush_restart_latency", lat, 33);

    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = 32'($urandom_range(1, 20));
        2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        default: ;
      endcase
      run_op(op, a, b, res, lat, stalls);
      chk($sformatf("rand%0d_op%0d_%h_%h", n, op, a, b), res, ref_md(op, a, b));
      chk($sformatf("rand%0d_latency", n), lat, (op[2] && b == 0) ? 1 : 33);
    end

    // Asynchronous reset in the middle of a multiply.
    run_op(3'd0, 32'h00000007, 32'hFFFFFFFD, res, lat, stalls);
    chk("prereset_result", res, 32'hFFFFFFEB);
    @(negedge clk);
    md.MDOpE = 3'd0; md.SrcAE = 32'd9; md.SrcBE = 32'd9; md.MDStartE = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    rst_n = 1'b0;
    md.MDStartE = 1'b0;
    #1;
    chk("midreset_stall", {31'b0, md.MDStallE}, 32'd0);
    chk("midreset_valid", {31'b0, md.MDValidE}, 32'd0);
    chk("midreset_busy",  {31'b0, md.MDBusy},   32'd0);
    chk("midreset_result", md.MDResultE, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back MUL then DIV with start held across the DONE slot.
    pulses = 0; first_k = -1; second_k = -1; r1 = '0; r2 = '0;
    @(negedge clk);
    md.MDOpE = 3'd0; md.SrcAE = 32'd7; md.SrcBE = 32'd3; md.MDStartE = 1'b1;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (md.MDValidE) begin
        pulses++;
        if (pulses == 1) begin
          first_k = k; r1 = md.MDResultE;
          md.MDOpE = 3'd5; md.SrcAE = 32'd100; md.SrcBE = 32'd7;
        end else if (pulses == 2) begin
          second_k = k; r2 = md.MDResultE;
          md.MDStartE = 1'b0;
        end
      end
      @(negedge clk);
    end
    md.MDStartE = 1'b0;
    chk("b2b_pulses", pulses, 2);
    chk("b2b_first_at", first_k, 33);
    chk("b2b_gap", second_k - first_k, 34);
    chk("b2b_mul_result", r1, 32'd21);
    chk("b2b_div_result", r2, 32'd14);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
